// File: rtl/rca64.sv
// rca64: 64-bit ripple-carry adder with a single output register stage.
// Serves as the slow baseline adder. The carry runs bit by bit from bit 0 up
// to bit 63, and that ripple is deliberately left as the critical path.
module rca64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        carryInput,
    output logic [63:0] sum,
    output logic        carryOutput
);

    // carryChain[i] is the carry into bit i.
    // carryChain[64] is the carry out of the most significant cell.
    logic [64:0] carryChain;
    logic [63:0] sum_d;
    logic        carryOut_d;
    logic [63:0] sum_q;
    logic        carryOut_q;

    assign carryChain[0] = carryInput;

    // One full-adder cell per bit position. Each cell feeds its carry
    // straight into the next cell, with no lookahead or select logic.
    for (genvar i = 0; i < 64; i++) begin : gCell
        assign sum_d[i]          = a[i] ^ b[i] ^ carryChain[i];
        assign carryChain[i + 1] = (a[i] & b[i]) | (a[i] & carryChain[i]) | (b[i] & carryChain[i]);
    end

    assign carryOut_d = carryChain[64];

    // Capture the combinational result on every edge. Reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= 64'd0;
            carryOut_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carryOut_q <= carryOut_d;
        end
    end

    assign sum         = sum_q;
    assign carryOutput = carryOut_q;

endmodule

// File: tb/tb_rca64.sv
// tb_rca64: self-checking bench for rca64.
// The expected result comes from plain 65-bit arithmetic on the operands.
module tb_rca64;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        carryInput;
    logic [63:0] sum;
    logic        carryOutput;

    int total;
    int bad;

    rca64 dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .carryInput  (carryInput),
        .sum         (sum),
        .carryOutput (carryOutput)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the registered outputs against the values the bench expects.
    task automatic checkOutput(input string tag, input logic [63:0] expSum, input logic expCout);
        total++;
        assert (sum === expSum && carryOutput === expCout)
        else begin
            bad++;
            $error("[TB] FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
                   tag, sum, carryOutput, expSum, expCout);
        end
    endtask

    // Drive one cycle of inputs and wait one edge. Then check the outputs
    // against the reference model.
    task automatic applyStimulus(input string tag, input logic rstIn, input logic [63:0] aIn,
                                 input logic [63:0] bIn, input logic cinIn);
        logic [64:0] model;
        rst        = rstIn;
        a          = aIn;
        b          = bIn;
        carryInput = cinIn;
        if (rstIn)
            model = 65'd0;
        else
            model = {1'b0, aIn} + {1'b0, bIn} + {64'd0, cinIn};
        @(posedge clk);
        #1;
        checkOutput(tag, model[63:0], model[64]);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        a          = 64'h0123_4567_89AB_CDEF;
        b          = 64'hFEDC_BA98_7654_3210;
        carryInput = 1'b1;

        // Reset for two edges while the operands are nonzero.
        applyStimulus("reset0", 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        applyStimulus("reset1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // First result after reset, also checked against the literal answer.
        applyStimulus("first", 1'b0, 64'd45622127699800, 64'd39879961242700, 1'b0);
        checkOutput("firstLit", 64'd85502088942500, 1'b0);

        // Back-to-back operand sets, one per cycle.
        applyStimulus("b2b0", 1'b0, 64'd123450967890, 64'd987456765432190, 1'b0);
        checkOutput("b2b0Lit", 64'd987580216400080, 1'b0);
        applyStimulus("b2b1", 1'b0, 64'd135792462378801, 64'd246809823135792, 1'b1);
        checkOutput("b2b1Lit", 64'd382602285514594, 1'b0);
        applyStimulus("b2b2", 1'b0, 64'd191542756779004, 64'd953884934268, 1'b0);
        checkOutput("b2b2Lit", 64'd192496641713272, 1'b0);

        // Large operands.
        applyStimulus("large", 1'b0, 64'd744073706477489551, 64'd1257488446744071615, 1'b0);
        checkOutput("largeLit", 64'd2001562153221561166, 1'b0);

        // Overflow and wrap-around.
        applyStimulus("ovf0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checkOutput("ovf0Lit", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        applyStimulus("ovf1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        checkOutput("ovf1Lit", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Full-length ripple and a carry out of the top bit only.
        applyStimulus("ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        checkOutput("rippleLit", 64'd0, 1'b1);
        applyStimulus("topBit", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        checkOutput("topBitLit", 64'd0, 1'b1);

        // Reset asserted mid-stream, then release it.
        applyStimulus("midRst", 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
        applyStimulus("postRst", 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1);
        checkOutput("postRstLit", 64'h6666_8888_AAAA_CCCD, 1'b0);

        // Random operands, with an occasional reset mixed in.
        for (int i = 0; i < 60; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rc;
            logic        rr;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 15) == 0);
            applyStimulus("random", rr, ra, rb, rc);
        end

        // Walking single-bit carry: (2^k - 1) + 1 ripples up to bit k.
        for (int k = 1; k < 64; k += 7) begin
            logic [63:0] ones;
            ones = (64'd1 << k) - 64'd1;
            applyStimulus("walk", 1'b0, ones, 64'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
